ddr3_line_ui_bridge: RTL and testbench

- Downstream stage of the DDR3 line cache controller. Accepts one 256-bit cache-line read or write per request on the ctrl_* line interface.
- Converts each request into two 128-bit commands on the DDR3 memory-controller user interface (app_*): x16 DDR3, BL8, 4:1.
- Returns the line and a one-cycle ack. Also issues the one-time post-calibration ack that the cache controller waits for at start-up.

---
 rtl/ddr3_line_ui_bridge.sv | 166 ++++++++++++++++
 tb/tb_ddr3_line_ui_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_line_ui_bridge.sv
// Splits each 256-bit cache-line read/write into two 128-bit DDR3 UI commands and beats.
// Optional request watchdog is enabled by defining DDR3_LINE_TIMEOUT_EN.
module ddr3_line_ui_bridge #(
   parameter int APP_ADDR_W     = 28,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [28:0]           addr_i,
   input  logic [255:0]          data_i,
   output logic [255:0]          data_o,
   input  logic                  we_i,
   input  logic                  rd_i,
   output logic                  ack_o,
   output logic [APP_ADDR_W-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [127:0]          app_wdf_data,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   output logic [15:0]           app_wdf_mask,
   input  logic                  app_wdf_rdy,
   input  logic [127:0]          app_rd_data,
   input  logic                  app_rd_data_valid,
   input  logic                  init_calib_complete,
   output logic                  error_o,
   output logic [15:0]           state_value
);

   localparam logic [2:0] S_CALIB    = 3'd0;
   localparam logic [2:0] S_IDLE     = 3'd1;
   localparam logic [2:0] S_INIT_ACK = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_READ     = 3'd4;
   localparam logic [2:0] S_ACK      = 3'd5;

   logic [2:0]   state;
   logic [1:0]   cmd_cnt, beat_cnt, cmd_nxt, beat_nxt;
   logic [127:0] wr_hi;
   logic [255:0] rd_buf, rd_line;
   logic         busy, cmd_acc, beat_acc, done, timeout;
   logic         unused_addr_bits;

   assign unused_addr_bits = ^addr_i[4:0];
   assign app_wdf_end      = app_wdf_wren;
   assign app_wdf_mask     = 16'h0000;
   assign state_value      = {13'b0, state};

   // Both channels count acceptances independently; the transaction ends when both reach two.
   always_comb begin
      busy     = (state == S_WRITE) || (state == S_READ);
      cmd_acc  = app_en && app_rdy;
      beat_acc = 1'b0;
      if (state == S_WRITE)
         beat_acc = app_wdf_wren && app_wdf_rdy;
      else if (state == S_READ)
         beat_acc = app_rd_data_valid && (beat_cnt != 2'd2);
      cmd_nxt  = (cmd_acc && cmd_cnt != 2'd2) ? cmd_cnt + 2'd1 : cmd_cnt;
      beat_nxt = (beat_acc && beat_cnt != 2'd2) ? beat_cnt + 2'd1 : beat_cnt;
      done     = busy && (cmd_nxt == 2'd2) && (beat_nxt == 2'd2);
      rd_line  = rd_buf;
      if (state == S_READ && beat_acc) begin
         if (beat_cnt[0])
            rd_line[255:128] = app_rd_data;
         else
            rd_line[127:0] = app_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_CALIB;
         ack_o        <= 1'b0;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
         data_o       <= '0;
         app_addr     <= '0;
         app_cmd      <= 3'b001;
         cmd_cnt      <= 2'd0;
         beat_cnt     <= 2'd0;
      end else begin
         ack_o <= 1'b0;
         case (state)
            S_CALIB: begin
               if (init_calib_complete) begin
                  state <= S_INIT_ACK;
                  ack_o <= 1'b1;
               end
            end
            S_INIT_ACK: state <= S_IDLE;
            S_IDLE: begin
               if (we_i || rd_i) begin
                  state        <= we_i ? S_WRITE : S_READ;
                  app_en       <= 1'b1;
                  app_addr     <= APP_ADDR_W'({addr_i[28:5], 4'b0000});
                  app_cmd      <= we_i ? 3'b000 : 3'b001;
                  app_wdf_wren <= we_i;
                  cmd_cnt      <= 2'd0;
                  beat_cnt     <= 2'd0;
               end
            end
            S_WRITE, S_READ: begin
               cmd_cnt  <= cmd_nxt;
               beat_cnt <= beat_nxt;
               if (cmd_acc) begin
                  if (cmd_nxt == 2'd2)
                     app_en <= 1'b0;
                  else
                     app_addr <= app_addr + APP_ADDR_W'(8);
               end
               if (state == S_WRITE && beat_acc && beat_nxt == 2'd2)
                  app_wdf_wren <= 1'b0;
               if (done || timeout) begin
                  state        <= S_ACK;
                  ack_o        <= 1'b1;
                  app_en       <= 1'b0;
                  app_wdf_wren <= 1'b0;
                  if (state == S_READ)
                     data_o <= done ? rd_line : {8{32'hDEAD_BEEF}};
               end
            end
            S_ACK: state <= S_IDLE;
            default: state <= S_CALIB;
         endcase
      end
   end

   // Line payload registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && we_i) begin
         wr_hi        <= data_i[255:128];
         app_wdf_data <= data_i[127:0];
      end else if (state == S_WRITE && beat_acc && beat_cnt == 2'd0) begin
         app_wdf_data <= wr_hi;
      end
      if (state == S_READ)
         rd_buf <= rd_line;
   end

`ifdef DDR3_LINE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   assign timeout = busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt  <= '0;
         error_o <= 1'b0;
      end else begin
         if (!busy)
            to_cnt <= '0;
         else if (!timeout)
            to_cnt <= to_cnt + TO_W'(1);
         if (timeout && !done)
            error_o <= 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_line_ui_bridge.sv
// Randomized scoreboard bench for ddr3_line_ui_bridge: driver pushes expectations, monitor checks.
module tb_ddr3_line_ui_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic [28:0]  addr_i;
   logic [255:0] data_i;
   logic [255:0] data_o;
   logic         we_i, rd_i, ack_o;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en, app_rdy;
   logic [127:0] app_wdf_data;
   logic         app_wdf_wren, app_wdf_end;
   logic [15:0]  app_wdf_mask;
   logic         app_wdf_rdy;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         init_calib_complete;
   logic         error_o;
   logic [15:0]  state_value;

   ddr3_line_ui_bridge dut (
      .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
      .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .init_calib_complete(init_calib_complete), .error_o(error_o), .state_value(state_value)
   );

   always #5 clk = ~clk;

   // Scoreboard queues: pushed by the driver, popped by the monitor.
   logic [30:0]  exp_cmd[$];
   logic [127:0] exp_beat[$];
   logic [255:0] exp_ack[$];
   string        chk_name[$];
   logic [255:0] chk_act[$];
   logic [255:0] chk_exp[$];

   // Memory-side model state, owned by the driver.
   logic [127:0] rd_q[$];
   int           pending;
   int           beat_budget;
   bit           beat_sent;
   int           rdy_mode;
   bit           wrdy_rand;
   bit           b2b;
   logic [255:0] model_last;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [255:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected, observed %h", name, act);
   endtask

   always @(negedge clk) begin
      while (chk_name.size() != 0)
         check(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
      if (!rst) begin
         if (app_en && app_rdy) begin
            if (exp_cmd.size() == 0) flag("cmd", 256'({app_addr, app_cmd}));
            else check("cmd", 256'({app_addr, app_cmd}), 256'(exp_cmd.pop_front()));
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            if (exp_beat.size() == 0) flag("wbeat", 256'(app_wdf_data));
            else check("wbeat", 256'(app_wdf_data), 256'(exp_beat.pop_front()));
            check("wdf_end_mask", 256'({app_wdf_end, app_wdf_mask}), 256'({1'b1, 16'h0000}));
         end
         if (ack_o) begin
            if (exp_ack.size() == 0) flag("ack", data_o);
            else check("ack_data", data_o, exp_ack.pop_front());
         end
      end
   end

   task automatic post(input string name, input logic [255:0] act, input logic [255:0] exp);
      chk_name.push_back(name);
      chk_act.push_back(act);
      chk_exp.push_back(exp);
   endtask

   task automatic sample_half();
      @(negedge clk);
      if (!rst && app_en && app_rdy && app_cmd == 3'b001) pending++;
   endtask

   task automatic drive_half();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: app_rdy = 1'($urandom_range(0, 1));
         1: app_rdy = ~app_rdy;
         default: app_rdy = 1'b1;
      endcase
      app_wdf_rdy       = wrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      app_rd_data_valid = 1'b0;
      beat_sent         = 1'b0;
      if (pending > 0 && rd_q.size() > 0 && beat_budget > 0 &&
          (b2b || $urandom_range(0, 2) != 0)) begin
         app_rd_data_valid = 1'b1;
         app_rd_data       = rd_q.pop_front();
         pending--;
         beat_budget--;
         beat_sent = 1'b1;
      end else begin
         app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic tick();
      sample_half();
      drive_half();
   endtask

   // Expected UI traffic and ack for one line request, straight from the addressing rules.
   task automatic push_exp(input bit we, input logic [28:0] a, input logic [255:0] d);
      logic [27:0]  base;
      logic [127:0] ba, bb;
      base = {a[28:5], 4'b0000};
      exp_cmd.push_back({base, we ? 3'b000 : 3'b001});
      exp_cmd.push_back({base + 28'd8, we ? 3'b000 : 3'b001});
      if (we) begin
         exp_beat.push_back(d[127:0]);
         exp_beat.push_back(d[255:128]);
      end else begin
         ba = {$urandom, $urandom, $urandom, $urandom};
         bb = {$urandom, $urandom, $urandom, $urandom};
         rd_q.push_back(ba);
         rd_q.push_back(bb);
         model_last = {bb, ba};
      end
      exp_ack.push_back(model_last);
   endtask

   task automatic wait_ack(input bit nwe, input bit nrd);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         sample_half();
         if (ack_o) begin
            got  = 1'b1;
            we_i = nwe;
            rd_i = nrd;
         end
         drive_half();
      end
      if (!got) begin
         post("ack_timeout", 256'(0), 256'(1));
         we_i = 1'b0;
         rd_i = 1'b0;
      end
   endtask

   task automatic post_reset_values();
      post("rst_state",   256'(state_value),  256'(0));
      post("rst_ack",     256'(ack_o),        256'(0));
      post("rst_app_en",  256'(app_en),       256'(0));
      post("rst_wren",    256'(app_wdf_wren), 256'(0));
      post("rst_data_o",  data_o,             256'(0));
      post("rst_addr",    256'(app_addr),     256'(0));
      post("rst_cmd",     256'(app_cmd),      256'(3'b001));
      post("rst_error",   256'(error_o),      256'(0));
   endtask

   initial begin
      logic [255:0] d;
      logic [28:0]  a;
      int           r;
      rst = 1'b1; we_i = 1'b0; rd_i = 1'b0; addr_i = '0; data_i = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
      init_calib_complete = 1'b0;
      pending = 0; beat_budget = 1000000; rdy_mode = 2; wrdy_rand = 1'b0; b2b = 1'b0;
      model_last = '0;
      #1;
      post_reset_values();
      drive_half();
      drive_half();
      rst = 1'b0;

      // Calibration wait then the single start-up ack
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i == 25) post("calib_state", 256'(state_value), 256'(0));
      end
      exp_ack.push_back(model_last);
      init_calib_complete = 1'b1;
      wait_ack(1'b0, 1'b0);
      sample_half();
      post("idle_after_calib", 256'(state_value), 256'(1));
      drive_half();

      // Directed write with app_rdy toggling
      rdy_mode = 1;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push_exp(1'b1, 29'h0000_1020, d);
      addr_i = 29'h0000_1020; data_i = d; we_i = 1'b1;
      wait_ack(1'b0, 1'b0);
      tick();

      // Directed read at the top of memory with back-to-back beats
      rdy_mode = 2; b2b = 1'b1;
      push_exp(1'b0, 29'h1FFF_FFE0, '0);
      addr_i = 29'h1FFF_FFE0; rd_i = 1'b1;
      wait_ack(1'b0, 1'b0);
      tick();

      // we_i and rd_i together: write wins, held rd_i re-accepted after one idle cycle
      a = 29'h0ABC_DE40;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push_exp(1'b1, a, d);
      addr_i = a; data_i = d; we_i = 1'b1; rd_i = 1'b1;
      wait_ack(1'b0, 1'b1);
      push_exp(1'b0, a, '0);
      sample_half();
      post("reaccept_gap", 256'(app_en), 256'(0));
      drive_half();
      sample_half();
      post("reaccept_en", 256'(app_en), 256'(1));
      drive_half();
      wait_ack(1'b0, 1'b0);
      tick();

      // Reset in the middle of a read, after its first beat
      b2b = 1'b1; beat_budget = 1;
      push_exp(1'b0, 29'h0123_4560, '0);
      addr_i = 29'h0123_4560; rd_i = 1'b1;
      for (int i = 0; i < 50 && !beat_sent; i++) tick();
      tick();
      #2;
      rst = 1'b1;
      rd_i = 1'b0;
      #1;
      post_reset_values();
      exp_cmd.delete(); exp_beat.delete(); exp_ack.delete();
      model_last = '0;
      beat_budget = 0;
      init_calib_complete = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      pending = rd_q.size();
      beat_budget = 1000000;
      repeat (4) tick();
      rd_q.delete();
      pending = 0;
      post("late_beat_data_o", data_o, 256'(0));
      post("late_beat_state", 256'(state_value), 256'(0));
      exp_ack.push_back(model_last);
      init_calib_complete = 1'b1;
      wait_ack(1'b0, 1'b0);
      tick();

      // Randomized traffic with random readiness and beat gaps
      rdy_mode = 0; wrdy_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(1, 3);
         b2b = 1'($urandom_range(0, 1));
         a = 29'($urandom);
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         push_exp(r[0], a, d);
         addr_i = a; data_i = d; we_i = r[0]; rd_i = r[1];
         wait_ack(1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (5) tick();
      post("left_cmd",  256'(exp_cmd.size()),  256'(0));
      post("left_beat", 256'(exp_beat.size()), 256'(0));
      post("left_ack",  256'(exp_ack.size()),  256'(0));
      post("error_o",   256'(error_o),         256'(0));
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
